// File: rtl/dram_bus_arb_if.sv
// Request/response bus shared by the two upstream masters and the DRAM side.
// IDW is 3 on the master side and 4 downstream, where bit 3 carries the master index.
interface dram_bus_arb_if #(
  parameter int ADRW = 32,
  parameter int DATW = 32,
  parameter int IDW  = 3
);
  logic            awvalid;
  logic            awready;
  logic [IDW-1:0]  awid;
  logic [ADRW-1:0] awaddr;
  logic [5:0]      awatop;
  logic            wvalid;
  logic            wready;
  logic [DATW-1:0] wdata;
  logic            wlast;
  logic            bvalid;
  logic            bready;
  logic [IDW-1:0]  bid;
  logic            bcomp;
  logic            arvalid;
  logic            arready;
  logic [IDW-1:0]  arid;
  logic [ADRW-1:0] araddr;
  logic            rvalid;
  logic            rready;
  logic [IDW-1:0]  rid;
  logic [DATW-1:0] rdata;
  logic            rlast;

  modport master (
    output awvalid, awid, awaddr, awatop, wvalid, wdata, wlast, bready,
           arvalid, arid, araddr, rready,
    input  awready, wready, bvalid, bid, bcomp, arready, rvalid, rid, rdata, rlast
  );

  modport slave (
    input  awvalid, awid, awaddr, awatop, wvalid, wdata, wlast, bready,
           arvalid, arid, araddr, rready,
    output awready, wready, bvalid, bid, bcomp, arready, rvalid, rid, rdata, rlast
  );
endinterface

// File: rtl/dram_bus_arb.sv
// Two-master arbiter in front of the DRAM interface; write and read channels are granted independently.
// Define ARB_FIXED_PRIO_EN to make master 0 win every tie instead of round-robin.
module dram_bus_arb #(
  parameter int ADRW = 32,
  parameter int DATW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  dram_bus_arb_if.slave  m0,
  dram_bus_arb_if.slave  m1,
  dram_bus_arb_if.master dram
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_t;
  typedef enum logic       {R_IDLE, R_ADDR}         r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;
  logic     w_gnt_reg, w_gnt_next;
  logic     r_gnt_reg, r_gnt_next;
  logic     w_pick, r_pick;
  logic     w_done, r_done;

  logic [ADRW-1:0] aw_addr_sel, ar_addr_sel;
  logic [DATW-1:0] w_data_sel;
  logic            w_valid_sel, w_last_sel;

`ifdef ARB_FIXED_PRIO_EN
  assign w_pick = ~m0.awvalid;
  assign r_pick = ~m0.arvalid;
`else
  logic w_ptr_reg, r_ptr_reg;

  // On a tie the pointer names the winner; otherwise whoever is requesting wins.
  assign w_pick = (m0.awvalid & m1.awvalid) ? w_ptr_reg : m1.awvalid;
  assign r_pick = (m0.arvalid & m1.arvalid) ? r_ptr_reg : m1.arvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_reg <= 1'b0;
      r_ptr_reg <= 1'b0;
    end else begin
      if (w_done) w_ptr_reg <= ~w_gnt_reg;
      if (r_done) r_ptr_reg <= ~r_gnt_reg;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg <= W_IDLE;
      r_state_reg <= R_IDLE;
      w_gnt_reg   <= 1'b0;
      r_gnt_reg   <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
      w_gnt_reg   <= w_gnt_next;
      r_gnt_reg   <= r_gnt_next;
    end
  end

  assign aw_addr_sel  = w_gnt_reg ? m1.awaddr : m0.awaddr;
  assign w_data_sel   = w_gnt_reg ? m1.wdata  : m0.wdata;
  assign w_valid_sel  = w_gnt_reg ? m1.wvalid : m0.wvalid;
  assign w_last_sel   = w_gnt_reg ? m1.wlast  : m0.wlast;
  assign ar_addr_sel  = r_gnt_reg ? m1.araddr : m0.araddr;

  assign dram.awid    = {w_gnt_reg, (w_gnt_reg ? m1.awid : m0.awid)};
  assign dram.awaddr  = aw_addr_sel;
  assign dram.awatop  = w_gnt_reg ? m1.awatop : m0.awatop;
  assign dram.wdata   = w_data_sel;
  assign dram.wlast   = w_last_sel;
  assign dram.arid    = {r_gnt_reg, (r_gnt_reg ? m1.arid : m0.arid)};
  assign dram.araddr  = ar_addr_sel;

  // The write grant is held from AW through the wlast beat so bursts never interleave.
  always_comb begin
    w_state_next = w_state_reg;
    w_gnt_next   = w_gnt_reg;
    w_done       = 1'b0;
    dram.awvalid = 1'b0;
    dram.wvalid  = 1'b0;
    m0.awready   = 1'b0;
    m1.awready   = 1'b0;
    m0.wready    = 1'b0;
    m1.wready    = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (m0.awvalid | m1.awvalid) begin
          w_gnt_next   = w_pick;
          w_state_next = W_ADDR;
        end
      end
      W_ADDR: begin
        dram.awvalid = 1'b1;
        m0.awready   = ~w_gnt_reg & dram.awready;
        m1.awready   =  w_gnt_reg & dram.awready;
        if (dram.awready) w_state_next = W_DATA;
      end
      W_DATA: begin
        dram.wvalid = w_valid_sel;
        m0.wready   = ~w_gnt_reg & dram.wready;
        m1.wready   =  w_gnt_reg & dram.wready;
        w_done      = w_valid_sel & dram.wready & w_last_sel;
        if (w_done) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;
    r_gnt_next   = r_gnt_reg;
    r_done       = 1'b0;
    dram.arvalid = 1'b0;
    m0.arready   = 1'b0;
    m1.arready   = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        if (m0.arvalid | m1.arvalid) begin
          r_gnt_next   = r_pick;
          r_state_next = R_ADDR;
        end
      end
      R_ADDR: begin
        dram.arvalid = 1'b1;
        m0.arready   = ~r_gnt_reg & dram.arready;
        m1.arready   =  r_gnt_reg & dram.arready;
        r_done       = dram.arready;
        if (dram.arready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Responses are steered purely by the master bit in the returned id.
  assign m0.bvalid  = dram.bvalid & ~dram.bid[3];
  assign m1.bvalid  = dram.bvalid &  dram.bid[3];
  assign dram.bready = dram.bid[3] ? m1.bready : m0.bready;
  assign m0.bid     = dram.bid[2:0];
  assign m1.bid     = dram.bid[2:0];
  assign m0.bcomp   = dram.bcomp;
  assign m1.bcomp   = dram.bcomp;

  assign m0.rvalid  = dram.rvalid & ~dram.rid[3];
  assign m1.rvalid  = dram.rvalid &  dram.rid[3];
  assign dram.rready = dram.rid[3] ? m1.rready : m0.rready;
  assign m0.rid     = dram.rid[2:0];
  assign m1.rid     = dram.rid[2:0];
  assign m0.rdata   = dram.rdata;
  assign m1.rdata   = dram.rdata;
  assign m0.rlast   = dram.rlast;
  assign m1.rlast   = dram.rlast;

endmodule
